// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding, default width
// and the default round length loaded at reset.
package timer_pkg;

    localparam int TIMER_WIDTH = 8;
    localparam logic [7:0] TIMER_ROUND_LEN = 8'd60;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_e;

endpackage

// File: rtl/countdown_timer.sv
// Tick-driven countdown timer with load/start/pause control and expiry flags.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN restarts the round from the reload register.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int               WIDTH     = TIMER_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(TIMER_ROUND_LEN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] remaining,
    output logic             running,
    output logic             expired,
    output logic             done_pulse
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             done_q, done_d;

    // Next-state and counter logic; load beats pause beats start beats tick.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        reload_d    = reload_q;
        done_d      = 1'b0;
        if (load) begin
            remaining_d = load_val;
            reload_d    = load_val;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!pause && start && (remaining_q != '0)) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (start) begin
                        state_d = RUN;
                    end else if (tick_in) begin
                        if (remaining_q > WIDTH'(1)) begin
                            remaining_d = remaining_q - WIDTH'(1);
                        end else begin
                            // Final tick: the count reaches zero on this edge.
                            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (reload_q != '0) begin
                                remaining_d = reload_q;
                                state_d     = RUN;
                            end else begin
                                remaining_d = '0;
                                state_d     = EXPIRED;
                            end
`else
                            remaining_d = '0;
                            state_d     = EXPIRED;
`endif
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                PAUSED: begin
                    if (!pause && start) begin
                        state_d = RUN;
                    end else begin
                        state_d = PAUSED;
                    end
                end
                EXPIRED: begin
                    remaining_d = '0;
                    state_d     = EXPIRED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    // State, count and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= RESET_VAL;
            reload_q    <= RESET_VAL;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            reload_q    <= reload_d;
            running_q   <= running_d;
            expired_q   <= expired_d;
            done_q      <= done_d;
        end
    end

    assign remaining  = remaining_q;
    assign running    = running_q;
    assign expired    = expired_q;
    assign done_pulse = done_q;

endmodule
